// File: rtl/univ_shift_reg_seq.sv
// -----------------------------------------------------------------------------
// univ_shift_reg_seq
//   WIDTH-bit universal register driven by a valid/ready command interface.
//   Commands: parallel LOAD, multi-step shift right (SHR), multi-step shift
//   left (SHL) and bitwise TOGGLE (JK "11" applied across the whole word).
//   Multi-bit shifts advance one bit per clock, sequenced by a down-counter.
//
//   Build option:
//     USR_ROTATE_EN  defined   -> shifts rotate (the bit shifted out re-enters
//                                 at the other end); ser_in is ignored.
//                    undefined -> the shifted-in bit is ser_in.
//
// Parameters
//   WIDTH   register width in bits (>= 2)
//   AMT_W   width of the shift-amount field (max count 2**AMT_W-1)
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      command can be accepted (state IDLE)
//   cmd_mode   in   2      00 LOAD, 01 SHR, 10 SHL, 11 TOGGLE
//   cmd_amt    in   AMT_W  shift count for SHR/SHL, ignored otherwise
//   load_data  in   WIDTH  parallel data for LOAD
//   ser_in     in   1      serial input bit, sampled on each shift edge
//   q          out  WIDTH  register contents
//   q_bar      out  WIDTH  ~q (combinational)
//   busy       out  1      multi-step shift in progress (state RUN)
//   done       out  1      one-cycle pulse after a command's final update
// -----------------------------------------------------------------------------
module univ_shift_reg_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    typedef enum logic [1:0] {
        MODE_LOAD   = 2'b00,
        MODE_SHR    = 2'b01,
        MODE_SHL    = 2'b10,
        MODE_TOGGLE = 2'b11
    } mode_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [AMT_W-1:0] rem_q,   rem_d;
    logic             left_q,  left_d;   // direction of the shift in progress
    logic             done_q,  done_d;

    mode_t            mode;
    logic             step_left;         // direction used by this cycle's step
    logic             shift_bit;
    logic [WIDTH-1:0] shifted;

    assign mode = mode_t'(cmd_mode);

    // ------------------------------------------------------------------
    // Single shift step. In IDLE the direction comes from the incoming
    // command; in RUN it comes from the latched direction.
    // ------------------------------------------------------------------
    always_comb begin
        step_left = (state_q == ST_RUN) ? left_q : (mode == MODE_SHL);
`ifdef USR_ROTATE_EN
        shift_bit = step_left ? data_q[WIDTH-1] : data_q[0];
`else
        shift_bit = ser_in;
`endif
        if (step_left) begin
            shifted = {data_q[WIDTH-2:0], shift_bit};
        end else begin
            shifted = {shift_bit, data_q[WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        left_d  = left_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    unique case (mode)
                        MODE_LOAD: begin
                            data_d = load_data;
                            done_d = 1'b1;
                        end
                        MODE_TOGGLE: begin
                            data_d = ~data_q;
                            done_d = 1'b1;
                        end
                        MODE_SHR, MODE_SHL: begin
                            if (cmd_amt == '0) begin
                                // zero-length shift: one-edge no-op
                                done_d = 1'b1;
                            end else begin
                                // first step lands on the accept edge
                                data_d = shifted;
                                left_d = (mode == MODE_SHL);
                                if (cmd_amt == AMT_W'(1)) begin
                                    done_d = 1'b1;
                                end else begin
                                    state_d = ST_RUN;
                                    rem_d   = cmd_amt - AMT_W'(1);
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_RUN: begin
                data_d = shifted;
                if (rem_q == AMT_W'(1)) begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    rem_d = rem_q - AMT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            left_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            left_q  <= left_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign q         = data_q;
    assign q_bar     = ~data_q;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;

endmodule

// File: tb/tb_univ_shift_reg_seq.sv
module tb_univ_shift_reg_seq;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned AMT_W = 4;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_mode;
    logic [AMT_W-1:0] cmd_amt;
    logic [WIDTH-1:0] load_data;
    logic             ser_in;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             busy;
    logic             done;

    int unsigned errors = 0;
    int unsigned checks = 0;

    univ_shift_reg_seq #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_amt   (cmd_amt),
        .load_data (load_data),
        .ser_in    (ser_in),
        .q         (q),
        .q_bar     (q_bar),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [1:0] m, input logic [3:0] a, input logic [7:0] d, input logic s);
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_amt   = a;
        load_data = d;
        ser_in    = s;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'b00; cmd_amt = '0;
        load_data = '0; ser_in = 1'b0;

        // reset state
        #12;
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_qbar", 32'(q_bar), 32'hFF);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        @(negedge clk); rst = 1'b0;

        // 1. LOAD 0xA5
        @(negedge clk); cmd(2'b00, 4'd0, 8'hA5, 1'b0);
        @(negedge clk);
        chk("load_q", 32'(q), 32'hA5);
        chk("load_qbar", 32'(q_bar), 32'h5A);
        chk("load_done", 32'(done), 1);
        chk("load_ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("load_done_clr", 32'(done), 0);
        chk("load_hold", 32'(q), 32'hA5);

        // 2. SHR amt=3 ser_in=1; LOAD attempts while busy must be ignored
        cmd(2'b01, 4'd3, 8'h00, 1'b1);
        @(negedge clk);
        chk("shr_s1", 32'(q), 32'hD2);
        chk("shr_busy1", 32'(busy), 1);
        chk("shr_ready1", 32'(cmd_ready), 0);
        chk("shr_done1", 32'(done), 0);
        cmd_mode = 2'b00;  // cmd_valid stays high with a LOAD 0x00
        @(negedge clk);
        chk("shr_s2", 32'(q), 32'hE9);
        chk("shr_busy2", 32'(busy), 1);
        chk("shr_done2", 32'(done), 0);
        @(negedge clk);
        chk("shr_s3", 32'(q), 32'hF4);
        chk("shr_busy3", 32'(busy), 0);
        chk("shr_done3", 32'(done), 1);
        chk("shr_ready3", 32'(cmd_ready), 1);

        // 3. SHL amt=2 ser_in=0 issued in the done cycle, then TOGGLE back-to-back
        cmd(2'b10, 4'd2, 8'h00, 1'b0);
        @(negedge clk);
        chk("shl_s1", 32'(q), 32'hE8);
        chk("shl_busy1", 32'(busy), 1);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("shl_s2", 32'(q), 32'hD0);
        chk("shl_done", 32'(done), 1);
        chk("shl_ready", 32'(cmd_ready), 1);
        cmd(2'b11, 4'd0, 8'h00, 1'b0);
        @(negedge clk);
        chk("tog_q", 32'(q), 32'h2F);
        chk("tog_done", 32'(done), 1);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("tog_done_clr", 32'(done), 0);

        // 4. SHR amt=0: no-op with a single done pulse
        cmd(2'b01, 4'd0, 8'h00, 1'b1);
        @(negedge clk);
        chk("amt0_q", 32'(q), 32'h2F);
        chk("amt0_done", 32'(done), 1);
        chk("amt0_busy", 32'(busy), 0);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("amt0_done_clr", 32'(done), 0);
        chk("amt0_busy2", 32'(busy), 0);
        chk("amt0_hold", 32'(q), 32'h2F);

        // 5. SHL amt=15 ser_in=0, reset asserted before step 5
        cmd(2'b10, 4'd15, 8'h00, 1'b0);
        @(negedge clk);
        chk("long_s1", 32'(q), 32'h5E);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("long_s2", 32'(q), 32'hBC);
        @(negedge clk);
        chk("long_s3", 32'(q), 32'h78);
        @(negedge clk);
        chk("long_s4", 32'(q), 32'hF0);
        chk("long_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("abort_q", 32'(q), 32'h00);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ready", 32'(cmd_ready), 1);
        chk("abort_done", 32'(done), 0);
        @(negedge clk);
        chk("abort_done2", 32'(done), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_done3", 32'(done), 0);
        chk("abort_q2", 32'(q), 32'h00);
        cmd(2'b00, 4'd0, 8'h3C, 1'b0);
        @(negedge clk);
        chk("post_load_q", 32'(q), 32'h3C);
        chk("post_load_done", 32'(done), 1);
        cmd_valid = 1'b0;
        @(negedge clk);

        // 6. shifts with the shifted-in bit source of this build
        cmd(2'b00, 4'd0, 8'h81, 1'b0);
        @(negedge clk);
        chk("rot_load", 32'(q), 32'h81);
        cmd(2'b10, 4'd1, 8'h00, 1'b0);
        @(negedge clk);
`ifdef USR_ROTATE_EN
        chk("rot_shl1", 32'(q), 32'h03);
`else
        chk("ser_shl1", 32'(q), 32'h02);
`endif
        chk("shl1_done", 32'(done), 1);
        chk("shl1_busy", 32'(busy), 0);
        cmd(2'b01, 4'd2, 8'h00, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
`ifdef USR_ROTATE_EN
        chk("rot_shr_s1", 32'(q), 32'h81);
`else
        chk("ser_shr_s1", 32'(q), 32'h81);
`endif
        @(negedge clk);
        chk("shr2_q", 32'(q), 32'hC0);
        chk("shr2_done", 32'(done), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
